// File: rtl/col_sum_serializer.sv
// ---------------------------------------------------------------------------
// col_sum_serializer
//
// Reduces transposed partial-product bit columns into the final product.
// For every output digit, the BIT_LEN columns that make it up are each
// popcounted and summed with a carry that ripples column to column. The
// carry is also carried from one digit to the next. The product is emitted
// LSB-first, one BIT_LEN-bit digit per beat, on a valid/ready stream.
//
// Ports
//   clk        : clock, all state on posedge
//   rst_n      : asynchronous active-low reset
//   start      : begin a reduction (accepted only when idle)
//   col        : [NUM_COLS][NUM_ELEMENTS] bit columns, stable start..done
//   busy       : high while digits are being produced
//   out_valid  : out_digit/out_idx/out_last are valid
//   out_ready  : sink accepts the digit on out_valid && out_ready
//   out_digit  : product digit, weight 2^(BIT_LEN*out_idx)
//   out_idx    : digit index 0..NUM_DIGITS-1
//   out_last   : marks digit NUM_DIGITS-1
//   done       : one-cycle pulse after the last digit handshake
//   stall_cnt  : (COL_SUM_STALL_CNT_EN only) RUN cycles with
//                out_valid && !out_ready, cleared on start, saturating
//
// Build option: define COL_SUM_STALL_CNT_EN to add the stall_cnt output.
// ---------------------------------------------------------------------------
module col_sum_serializer #(
    parameter int BIT_LEN      = 17,
    parameter int NUM_ELEMENTS = 62
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  start,
    input  logic [BIT_LEN*(2*NUM_ELEMENTS-1)-1:0][NUM_ELEMENTS-1:0] col,
    output logic                                                  busy,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [BIT_LEN-1:0]                                    out_digit,
    output logic [6:0]                                            out_idx,
    output logic                                                  out_last,
    output logic                                                  done
`ifdef COL_SUM_STALL_CNT_EN
    ,
    output logic [15:0]                                           stall_cnt
`endif
);

    localparam int NUM_COLS   = BIT_LEN * (2 * NUM_ELEMENTS - 1);
    localparam int NUM_DIGITS = 2 * NUM_ELEMENTS;
    localparam int CARRY_W    = $clog2(NUM_ELEMENTS);
    localparam int SUM_W      = CARRY_W + 1;
    localparam int PC_W       = $clog2(NUM_ELEMENTS + 1);
    localparam int IDX_W      = 7;
    // Column index spans the carry-only padding columns past NUM_COLS.
    localparam int COL_W      = $clog2(BIT_LEN * NUM_DIGITS);
    localparam int SEL_W      = $clog2(NUM_COLS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t               r_state;
    logic                 r_busy;
    logic                 r_valid;
    logic                 r_last;
    logic                 r_done;
    logic [BIT_LEN-1:0]   r_digit;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_d;
    logic [CARRY_W-1:0]   r_carry;

    logic [COL_W-1:0]        w_base;
    logic [COL_W-1:0]        w_c;
    logic [NUM_ELEMENTS-1:0] w_bits;
    logic [SUM_W-1:0]        w_sum;
    logic [BIT_LEN-1:0]      w_digit_nx;
    logic [CARRY_W-1:0]      w_carry_nx;
    logic                    w_load;

    function automatic logic [PC_W-1:0] f_popcount(input logic [NUM_ELEMENTS-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    assign w_base = COL_W'(r_d) * COL_W'(BIT_LEN);

    // Ripple the carry through the digit's columns, lowest weight first.
    // Columns beyond NUM_COLS contribute nothing, so the last digit is the
    // binary value of the residual carry.
    always_comb begin
        w_c        = '0;
        w_bits     = '0;
        w_sum      = '0;
        w_digit_nx = '0;
        w_carry_nx = r_carry;
        for (int unsigned k = 0; k < BIT_LEN; k++) begin
            w_c           = w_base + COL_W'(k);
            w_bits        = (w_c < COL_W'(NUM_COLS)) ? col[w_c[SEL_W-1:0]] : '0;
            w_sum         = SUM_W'(f_popcount(w_bits)) + SUM_W'(w_carry_nx);
            w_digit_nx[k] = w_sum[0];
            w_carry_nx    = w_sum[SUM_W-1:1];
        end
    end

    assign w_load = (!r_valid || out_ready) && (r_d < IDX_W'(NUM_DIGITS));

`ifdef COL_SUM_STALL_CNT_EN
    logic [15:0] r_stall;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_digit <= '0;
            r_idx   <= '0;
            r_d     <= '0;
            r_carry <= '0;
`ifdef COL_SUM_STALL_CNT_EN
            r_stall <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        r_d     <= '0;
                        r_carry <= '0;
`ifdef COL_SUM_STALL_CNT_EN
                        r_stall <= '0;
`endif
                    end
                end
                S_RUN: begin
                    if (r_valid && out_ready && r_last) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else if (w_load) begin
                        r_digit <= w_digit_nx;
                        r_idx   <= r_d;
                        r_last  <= (r_d == IDX_W'(NUM_DIGITS - 1));
                        r_valid <= 1'b1;
                        r_carry <= w_carry_nx;
                        r_d     <= r_d + 1'b1;
                    end
`ifdef COL_SUM_STALL_CNT_EN
                    if (r_valid && !out_ready && (r_stall != '1)) begin
                        r_stall <= r_stall + 1'b1;
                    end
`endif
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_valid;
    assign out_digit = r_digit;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign done      = r_done;
`ifdef COL_SUM_STALL_CNT_EN
    assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_col_sum_serializer.sv
module tb_col_sum_serializer;

    localparam int BL = 17;
    localparam int NE = 62;
    localparam int NC = BL * (2 * NE - 1);
    localparam int ND = 2 * NE;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic [NC-1:0][NE-1:0]  col;
    logic                   busy;
    logic                   out_valid;
    logic                   out_ready;
    logic [BL-1:0]          out_digit;
    logic [6:0]             out_idx;
    logic                   out_last;
    logic                   done;
`ifdef COL_SUM_STALL_CNT_EN
    logic [15:0]            stall_cnt;
`endif

    always #5 clk = ~clk;

    col_sum_serializer #(
        .BIT_LEN      (BL),
        .NUM_ELEMENTS (NE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .col       (col),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done)
`ifdef COL_SUM_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // One stream scenario: column pattern, expected digits as a default
    // value plus up to two exceptions (index -1 = none), and handshake mode.
    typedef struct {
        int          pat;
        logic [16:0] dflt;
        int          xi0;
        logic [16:0] xv0;
        int          xi1;
        logic [16:0] xv1;
        bit          rnd;
        bit          xstart;
        bit          start_at_done;
    } vec_t;

    vec_t        tbl[6];
    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_d[ND];
    int          stall_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_col(input int pat);
        col = '0;
        case (pat)
            1: col[0][0] = 1'b1;
            2: col[16]   = '1;
            3: col       = '1;
            4: col[30]   = '1;
            5: col[NC-1] = '1;
            default: col = '0;
        endcase
    endtask

    task automatic build_exp(input vec_t v);
        for (int i = 0; i < ND; i++) exp_d[i] = v.dflt;
        if (v.xi0 >= 0) exp_d[v.xi0] = v.xv0;
        if (v.xi1 >= 0) exp_d[v.xi1] = v.xv1;
    endtask

    task automatic run_stream(input vec_t v, input int stop_at);
        int beat;
        int cyc;
        set_col(v.pat);
        build_exp(v);
        stall_exp = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk($sformatf("p%0d_busy_after_start", v.pat), busy, 1);
        chk($sformatf("p%0d_valid_after_start", v.pat), out_valid, 0);
        beat = 0;
        cyc  = 0;
        while (beat < stop_at && cyc < 5000) begin
            out_ready = v.rnd ? ($urandom_range(99, 0) >= 30) : 1'b1;
            start     = v.xstart && (beat == 20);
            if (out_valid && out_ready) begin
                chk($sformatf("p%0d_digit%0d", v.pat, beat), out_digit, exp_d[beat]);
                chk($sformatf("p%0d_idx%0d", v.pat, beat), out_idx, beat);
                chk($sformatf("p%0d_last%0d", v.pat, beat), out_last, (beat == ND - 1));
                chk($sformatf("p%0d_done_early%0d", v.pat, beat), done, 0);
                beat++;
            end else if (out_valid) begin
                stall_exp++;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        if (beat < stop_at) begin
            chk($sformatf("p%0d_stream_timeout", v.pat), beat, stop_at);
            return;
        end
        if (stop_at < ND) return;
        if (!v.rnd) chk($sformatf("p%0d_cycles_full_rate", v.pat), cyc, ND + 1);
        chk($sformatf("p%0d_done_pulse", v.pat), done, 1);
        chk($sformatf("p%0d_busy_fin", v.pat), busy, 0);
        chk($sformatf("p%0d_valid_after_last", v.pat), out_valid, 0);
`ifdef COL_SUM_STALL_CNT_EN
        chk($sformatf("p%0d_stall_cnt", v.pat), stall_cnt, stall_exp);
`endif
        if (v.start_at_done) start = 1'b1;
        step();
        start = 1'b0;
        chk($sformatf("p%0d_done_cleared", v.pat), done, 0);
        chk($sformatf("p%0d_busy_idle", v.pat), busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        col       = '0;

        // pat, default, exceptions, random ready, extra start, start at done
        tbl[0] = '{0, 17'h00000, -1,     17'h00000, -1,     17'h00000, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1, 17'h00000,  0,     17'h00001, -1,     17'h00000, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{2, 17'h00000,  1,     17'h0001F, -1,     17'h00000, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{3, 17'h1FFFF,  0,     17'h1FFC2, ND - 1, 17'h0003D, 1'b0, 1'b0, 1'b0};
        // 62 << 30 = 0x7C000 << 17 : spans digits 1 and 2
        tbl[4] = '{4, 17'h00000,  1,     17'h1C000,  2,     17'h00003, 1'b1, 1'b1, 1'b0};
        // 62 at weight 2^2090 = 31 at weight 2^(17*123)
        tbl[5] = '{5, 17'h00000, ND - 1, 17'h0001F, -1,     17'h00000, 1'b0, 1'b0, 1'b0};

        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_digit", out_digit, 0);
        chk("rst_idx", out_idx, 0);
`ifdef COL_SUM_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_stream(tbl[i], ND);

        // Reset in the middle of a stream, asserted away from any edge.
        run_stream(tbl[3], 50);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_digit", out_digit, 0);
        chk("midrst_idx", out_idx, 0);
        chk("midrst_last", out_last, 0);
        chk("midrst_done", done, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("postrst_busy", busy, 0);
        chk("postrst_done", done, 0);
        run_stream(tbl[3], ND);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
